// File: rtl/rectangle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rectangle_pkg
//  Description : Shared types, defaults and ShiftRow helpers for the
//                RECTANGLE datapath. The ShiftRow mapping and its inverse
//                live here so the encryption and decryption paths stay in
//                lock-step.
//  Contents    : c_rounds / c_rot1..c_rot3 defaults, c_round_w,
//                state_t (64b), row_t (16b), round_t, beat_t,
//                rotl16 / rotr16, shift_row / inv_shift_row
//  Revision    : 1.0  initial release
// ============================================================================
package rectangle_pkg;

    localparam int unsigned c_rounds  = 25;
    localparam int unsigned c_rot1    = 1;
    localparam int unsigned c_rot2    = 12;
    localparam int unsigned c_rot3    = 13;
    localparam int unsigned c_round_w = 5;

    typedef logic [63:0]          state_t;
    typedef logic [15:0]          row_t;
    typedef logic [c_round_w-1:0] round_t;

    // One beat as carried through the skid buffer.
    typedef struct packed {
        state_t state;
        round_t round;
        logic   last;
    } beat_t;

    // Rotate a 16-bit row left; the doubled word lets the upper half
    // collect the wrapped bits without a separate OR term.
    function automatic row_t rotl16(input row_t x, input int unsigned n);
        logic [31:0] w_dbl;
        w_dbl = {x, x} << (n % 32'd16);
        return w_dbl[31:16];
    endfunction

    function automatic row_t rotr16(input row_t x, input int unsigned n);
        return rotl16(x, 32'd16 - (n % 32'd16));
    endfunction

    // Row r occupies bits [16r+15:16r]; row 0 is never rotated.
    function automatic state_t shift_row(input state_t s,
                                         input int unsigned rot1,
                                         input int unsigned rot2,
                                         input int unsigned rot3);
        state_t w_res;
        w_res[15:0]  = s[15:0];
        w_res[31:16] = rotl16(s[31:16], rot1);
        w_res[47:32] = rotl16(s[47:32], rot2);
        w_res[63:48] = rotl16(s[63:48], rot3);
        return w_res;
    endfunction

    function automatic state_t inv_shift_row(input state_t s,
                                             input int unsigned rot1,
                                             input int unsigned rot2,
                                             input int unsigned rot3);
        state_t w_res;
        w_res[15:0]  = s[15:0];
        w_res[31:16] = rotr16(s[31:16], rot1);
        w_res[47:32] = rotr16(s[47:32], rot2);
        w_res[63:48] = rotr16(s[63:48], rot3);
        return w_res;
    endfunction

endpackage : rectangle_pkg
`default_nettype wire

// File: rtl/rect_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rect_skid_buf
//  Description : Valid/ready pipeline register with one skid entry.
//                Output register plus skid register give full throughput
//                while keeping the upstream ready purely registered.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                i_data/i_valid    upstream beat
//                o_ready           upstream ready (registered)
//                o_data/o_valid    downstream beat (held until accepted)
//                i_ready           downstream ready
//  Revision    : 1.0  initial release
// ============================================================================
module rect_skid_buf #(
    parameter int WIDTH = 70
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_out_valid;
    // Ready doubles as "skid empty": the skid holds a beat exactly when
    // upstream is being refused, so no separate occupancy bit is needed.
    logic             r_in_ready;

    logic w_in_fire;
    logic w_out_free;

    assign w_in_fire  = i_valid & r_in_ready;
    // Output register can take a new beat this edge: empty, or draining.
    assign w_out_free = ~r_out_valid | i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_skid_data <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (w_out_free) begin
            if (!r_in_ready) begin
                // Skid entry is older than anything upstream: drain it first.
                r_out_data  <= r_skid_data;
                r_out_valid <= 1'b1;
                r_in_ready  <= 1'b1;
            end else if (w_in_fire) begin
                r_out_data  <= i_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            // Output stalled and full: park the beat, refuse the next one.
            r_skid_data <= i_data;
            r_in_ready  <= 1'b0;
        end
    end

    assign o_ready = r_in_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;

endmodule : rect_skid_buf
`default_nettype wire

// File: rtl/shift_row_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_row_stage
//  Description : RECTANGLE ShiftRow pipeline stage. Rotates rows 1..3 of the
//                64-bit state, tags each beat with its round index and
//                buffers it through a skid register. Flags a sticky error
//                when a block runs past ROUNDS without a new in_first.
//  Ports       : clk, rst                       clock, sync active-high reset
//                in_state/in_first/in_valid     upstream beat
//                in_ready                       upstream ready (registered)
//                out_state/out_round/out_last   downstream beat
//                out_valid/out_ready            downstream handshake
//                err                            sticky round overflow
//  Revision    : 1.0  initial release
// ============================================================================
module shift_row_stage
    import rectangle_pkg::*;
#(
    parameter int unsigned ROUNDS = c_rounds,
    parameter int unsigned ROT1   = c_rot1,
    parameter int unsigned ROT2   = c_rot2,
    parameter int unsigned ROT3   = c_rot3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          in_state,
    input  logic                 in_first,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [63:0]          out_state,
    output logic [c_round_w-1:0] out_round,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err
);

    localparam round_t c_last_round = round_t'(ROUNDS);
    localparam int     c_beat_w     = $bits(beat_t);

    round_t r_round;      // round of the most recently accepted beat
    logic   r_err;

    logic   w_in_ready;
    logic   w_in_fire;
    round_t w_beat_round;
    logic   w_overflow;
    beat_t  w_in_beat;
    beat_t  w_out_beat;

    assign w_in_fire = in_valid & w_in_ready;

    // Round tagging. A beat following round ROUNDS without in_first is an
    // overflow: it restarts at round 1 but raises err.
    always_comb begin
        w_beat_round = r_round + round_t'(1);
        w_overflow   = 1'b0;
        if (in_first) begin
            w_beat_round = round_t'(1);
        end else if (r_round == c_last_round) begin
            w_beat_round = round_t'(1);
            w_overflow   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_round <= '0;
            r_err   <= 1'b0;
        end else if (w_in_fire) begin
            r_round <= w_beat_round;
            if (w_overflow) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_in_beat       = '0;
        w_in_beat.state = shift_row(in_state, ROT1, ROT2, ROT3);
        w_in_beat.round = w_beat_round;
        w_in_beat.last  = (w_beat_round == c_last_round);
    end

    rect_skid_buf #(
        .WIDTH   (c_beat_w)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_in_beat),
        .i_valid (in_valid),
        .o_ready (w_in_ready),
        .o_data  (w_out_beat),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign in_ready  = w_in_ready;
    assign out_state = w_out_beat.state;
    assign out_round = w_out_beat.round;
    assign out_last  = w_out_beat.last;
    assign err       = r_err;

endmodule : shift_row_stage
`default_nettype wire

// File: tb/tb_shift_row_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_row_stage
//  Description : Directed and randomised self-checking bench for
//                shift_row_stage with default parameters
//                (ROUNDS=25, rotations 1/12/13).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_row_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_state;
    logic        in_first;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_state;
    logic [4:0]  out_round;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_row_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_state  (in_state),
        .in_first  (in_first),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_state (out_state),
        .out_round (out_round),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    // Reference ShiftRow written as explicit bit slices for rotations 1/12/13.
    function automatic logic [63:0] ref_sr(input logic [63:0] s);
        logic [15:0] r0, r1, r2, r3;
        r0 = s[15:0];
        r1 = s[31:16];
        r2 = s[47:32];
        r3 = s[63:48];
        return {{r3[2:0], r3[15:3]}, {r2[3:0], r2[15:4]}, {r1[14:0], r1[15]}, r0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0] q_state[$];
    logic [5:0]  q_tag[$];      // {round, last}

    initial begin
        logic [63:0] v_state;
        logic [4:0]  m_round;
        logic [4:0]  v_round;
        logic [5:0]  v_tag;
        int          acc;
        int          cyc;

        rst       = 1'b1;
        in_state  = '0;
        in_first  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step(); step(); step();

        // ---------------- reset state ----------------
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_state", out_state, 64'd0);
        chk("rst_out_round", 64'(out_round), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_err",       64'(err),       64'd0);
        rst = 1'b0;
        step();

        // ---------------- single beat ----------------
        in_state  = 64'h0001_0001_0001_0001;
        in_first  = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_state", out_state, 64'h2000_1000_0002_0001);
        chk("single_round", 64'(out_round), 64'd1);
        chk("single_last",  64'(out_last),  64'd0);
        step();
        chk("single_drain", 64'(out_valid), 64'd0);

        // ---------------- full block, back-to-back ----------------
        for (int i = 0; i < 25; i++) begin
            in_state = {16'(i), 16'(i * 7 + 3), 16'hA5A5 ^ 16'(i), 16'(i << 8)};
            in_first = (i == 0);
            in_valid = 1'b1;
            chk("blk_in_ready", 64'(in_ready), 64'd1);
            step();
            chk("blk_valid", 64'(out_valid), 64'd1);
            chk("blk_state", out_state, ref_sr(in_state));
            chk("blk_round", 64'(out_round), 64'(i + 1));
            chk("blk_last",  64'(out_last),  64'(i == 24));
        end
        in_valid = 1'b0;
        step();
        chk("blk_drain", 64'(out_valid), 64'd0);

        // ---------------- backpressure ----------------
        in_state = 64'h8000_8000_8000_8000;   // beat A
        in_first = 1'b1;
        in_valid = 1'b1;
        step();
        chk("bp_a_state", out_state, 64'h1000_0800_0001_8000);
        chk("bp_a_round", 64'(out_round), 64'd1);
        in_state  = 64'hFFFF_0000_1234_ABCD;  // beat B -> skid
        in_first  = 1'b0;
        out_ready = 1'b0;
        step();
        chk("bp_hold1_state", out_state, 64'h1000_0800_0001_8000);
        chk("bp_hold1_valid", 64'(out_valid), 64'd1);
        chk("bp_skid_ready",  64'(in_ready),  64'd0);
        in_state = 64'h000F_000F_000F_000F;   // beat C, refused for now
        step();
        chk("bp_hold2_state", out_state, 64'h1000_0800_0001_8000);
        chk("bp_hold2_ready", 64'(in_ready), 64'd0);
        step();
        chk("bp_hold3_state", out_state, 64'h1000_0800_0001_8000);
        chk("bp_hold3_round", 64'(out_round), 64'd1);
        chk("bp_hold3_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_b_state", out_state, 64'hFFFF_0000_2468_ABCD);
        chk("bp_b_round", 64'(out_round), 64'd2);
        chk("bp_b_valid", 64'(out_valid), 64'd1);
        chk("bp_b_ready", 64'(in_ready),  64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_c_state", out_state, 64'hE001_F000_001E_000F);
        chk("bp_c_round", 64'(out_round), 64'd3);
        step();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // ---------------- overflow ----------------
        for (int i = 0; i < 26; i++) begin
            in_state = {$urandom, $urandom};
            in_first = (i == 0);
            in_valid = 1'b1;
            step();
            chk("ovf_state", out_state, ref_sr(in_state));
            chk("ovf_round", 64'(out_round), (i < 25) ? 64'(i + 1) : 64'd1);
            chk("ovf_err",   64'(err),       (i < 25) ? 64'd0 : 64'd1);
            if (i == 24) chk("ovf_last25", 64'(out_last), 64'd1);
            if (i == 25) chk("ovf_last26", 64'(out_last), 64'd0);
        end
        in_valid = 1'b0;
        step(); step();
        chk("ovf_err_sticky", 64'(err), 64'd1);
        in_state = 64'h0123_4567_89AB_CDEF;
        in_first = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ovf_next_round", 64'(out_round), 64'd2);
        chk("ovf_next_err",   64'(err),       64'd1);
        step();

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        in_state  = 64'h1111_2222_3333_4444;
        in_first  = 1'b1;
        in_valid  = 1'b1;
        step();
        in_state = 64'h5555_6666_7777_8888;
        in_first = 1'b0;
        step();
        chk("mrst_full_ready", 64'(in_ready),  64'd0);
        chk("mrst_full_valid", 64'(out_valid), 64'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_state  = 64'h9999_AAAA_BBBB_CCCC;
        step();
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(in_ready),  64'd1);
        chk("mrst_err",   64'(err),       64'd0);
        chk("mrst_state", out_state, 64'd0);
        chk("mrst_round", 64'(out_round), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        chk("mrst_no_stale", 64'(out_valid), 64'd0);
        in_state = 64'hDEAD_BEEF_0F0F_F0F0;
        in_first = 1'b0;
        in_valid = 1'b1;
        step();
        chk("mrst_nofirst_round", 64'(out_round), 64'd1);
        chk("mrst_nofirst_err",   64'(err),       64'd0);
        chk("mrst_nofirst_state", out_state, ref_sr(in_state));
        in_first = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mrst_first_round", 64'(out_round), 64'd1);
        step();
        chk("mrst_drain", 64'(out_valid), 64'd0);

        // ---------------- random valid/ready with scoreboard ----------------
        m_round = 5'd1;
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_state  = {$urandom, $urandom};
            in_first  = (m_round == 5'd25) || ($urandom_range(0, 19) == 0);
            if (out_valid && out_ready) begin
                if (q_state.size() == 0) begin
                    chk("rand_spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    v_state = q_state.pop_front();
                    v_tag   = q_tag.pop_front();
                    chk("rand_state", out_state, v_state);
                    chk("rand_tag", 64'({out_round, out_last}), 64'(v_tag));
                end
            end
            if (in_valid && in_ready) begin
                if (in_first || m_round == 5'd25) v_round = 5'd1;
                else                              v_round = m_round + 5'd1;
                m_round = v_round;
                q_state.push_back(ref_sr(in_state));
                q_tag.push_back({v_round, v_round == 5'd25});
                acc++;
            end
            step();
            cyc++;
        end
        chk("rand_beats_accepted", 64'(acc), 64'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) begin
                if (q_state.size() == 0) begin
                    chk("rand_spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    v_state = q_state.pop_front();
                    v_tag   = q_tag.pop_front();
                    chk("rand_state", out_state, v_state);
                    chk("rand_tag", 64'({out_round, out_last}), 64'(v_tag));
                end
            end
            step();
        end
        chk("rand_queue_empty", 64'(q_state.size()), 64'd0);
        chk("rand_out_idle",    64'(out_valid),      64'd0);
        chk("rand_no_err",      64'(err),            64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_shift_row_stage
`default_nettype wire
